// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer.
// A WORDS x 16-bit operand pair is pushed through one 16-bit ripple adder,
// least significant slice first, with the carry held in a register between
// slices. The result, the carry out and the signed overflow are returned
// behind a start/ready/done handshake.

// 16-bit ripple-carry adder: the single arithmetic resource the sequencer shares.
module fa16 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout
);

    logic [16:0] w_c;

    assign w_c[0] = Cin;

    // One full adder per bit, carry chained from bit 0 upwards.
    for (genvar gi = 0; gi < 16; gi++) begin : g_bit
        assign S[gi]     = A[gi] ^ B[gi] ^ w_c[gi];
        assign w_c[gi+1] = (A[gi] & B[gi]) | (w_c[gi] & (A[gi] ^ B[gi]));
    end

    assign Cout = w_c[16];

endmodule

// Sequencer: latches both operands on an accepted start, then runs one
// slice per clock through fa16 and pulses done once the top slice is written.
//
// state  | meaning
// IDLE   | ready=1, waiting for start
// RUN    | one slice per clock through fa16, busy=1
// DONE   | done=1 for one cycle, result valid
module mp_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                ready,
    input  logic                op_sub,
    input  logic                cin,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] sum,
    output logic                cout,
    output logic                ovf
);

    localparam int N  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [N-1:0]    r_opa;
    logic [N-1:0]    r_opb;
    logic            r_carry;
    logic [N-1:0]    r_sum;
    logic            r_cout;
    logic            r_ovf;
    logic            r_ready;
    logic            r_busy;
    logic            r_done;

    logic [15:0]     w_a_slice;
    logic [15:0]     w_b_slice;
    logic [15:0]     w_s;
    logic            w_cout;
    logic            w_last;
    logic            w_ovf;

    // Slice select: the index is scaled by 16 by appending four zero bits.
    assign w_a_slice = r_opa[{r_idx, 4'b0000} +: 16];
    assign w_b_slice = r_opb[{r_idx, 4'b0000} +: 16];
    assign w_last    = (r_idx == IW'(WORDS - 1));

    // r_opb already holds ~b for subtract, so the usual same-sign rule applies.
    assign w_ovf = (r_opa[N-1] == r_opb[N-1]) && (w_s[15] != r_opa[N-1]);

    fa16 u_fa16 (
        .A    (w_a_slice),
        .B    (w_b_slice),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_cout)
    );

    // Handshake FSM, operand latches and slice-by-slice result accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opa   <= a;
                        r_opb   <= op_sub ? ~b : b;
                        r_carry <= op_sub ? 1'b1 : cin;
                        r_idx   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[{r_idx, 4'b0000} +: 16] <= w_s;
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_idx   <= '0;
                        r_cout  <= w_cout;
                        r_ovf   <= w_ovf;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;
    assign sum   = r_sum;
    assign cout  = r_cout;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq (WORDS=4): stimulus pushes the expected
// result when it issues start, a monitor pops and compares on every done.
module tb_mp_add_seq;

    localparam int WORDS = 4;
    localparam int N     = 16 * WORDS;

    logic         clk;
    logic         rst;
    logic         start;
    logic         ready;
    logic         op_sub;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;
    int   n_done  = 0;

    mp_add_seq #(.WORDS(WORDS)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ready  (ready),
        .op_sub (op_sub),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (q_exp.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk("sum",  sum, e.sum);
                chk("cout", {{(N-1){1'b0}}, cout}, {{(N-1){1'b0}}, e.cout});
                chk("ovf",  {{(N-1){1'b0}}, ovf},  {{(N-1){1'b0}}, e.ovf});
                chk("busy_at_done", {{(N-1){1'b0}}, busy}, '0);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    // Issue one operation; optionally fire ignored start pulses in RUN and DONE.
    task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                          input logic icin, input logic isub,
                          input logic [N-1:0] esum, input logic ecout,
                          input logic eovf, input bit noise);
        exp_t e;
        int   n;
        bit   got;
        wait_ready();
        e.sum  = esum;
        e.cout = ecout;
        e.ovf  = eovf;
        q_exp.push_back(e);
        n_acc++;
        a = ia; b = ib; cin = icin; op_sub = isub; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ia; b = ~ib; cin = ~icin; op_sub = ~isub;
        n = 0;
        got = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            chk("ready_low", {{(N-1){1'b0}}, ready}, '0);
            if (done) got = 1;
            if (noise) begin
                if (n == 2 || n == 3) begin
                    start = 1'b1;
                    a = 64'h0F0F_0F0F_0F0F_0F0F;
                    b = 64'h7777_7777_7777_7777;
                end else begin
                    start = 1'b0;
                end
                if (got) start = 1'b1;
            end
        end
        if (!got) chk("done_timeout", 0, 1);
        else chk("latency", N'(n), N'(WORDS + 1));
        if (noise) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] ra, rb, bb;
        logic         rc, rs, car, eov;
        logic [N:0]   full;

        rst = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        #12;
        chk("rst_ready", {{(N-1){1'b0}}, ready}, 1);
        chk("rst_busy",  {{(N-1){1'b0}}, busy},  0);
        chk("rst_done",  {{(N-1){1'b0}}, done},  0);
        chk("rst_sum",   sum, 0);
        chk("rst_cout",  {{(N-1){1'b0}}, cout},  0);
        chk("rst_ovf",   {{(N-1){1'b0}}, ovf},   0);
        @(negedge clk);
        rst = 1'b0;

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0);
        run_op(64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0, 0);
        run_op(64'h0, 64'h1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0);
        run_op(64'h5, 64'h3, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0, 0);

        // Ignored starts during RUN and DONE must not disturb this result.
        run_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
               64'h2345_6789_ABCD_F001, 1'b0, 1'b0, 1);
        repeat (8) @(negedge clk);
        chk("noise_one_done", N'(n_done), N'(n_acc));

        // Leave cout/ovf set so the mid-op reset has something to clear.
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
               64'h0, 1'b1, 1'b1, 0);

        wait_ready();
        a = 64'hAAAA_AAAA_AAAA_AAAA; b = '0; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {{(N-1){1'b0}}, ready}, 1);
        chk("mid_rst_busy",  {{(N-1){1'b0}}, busy},  0);
        chk("mid_rst_done",  {{(N-1){1'b0}}, done},  0);
        chk("mid_rst_sum",   sum, 0);
        chk("mid_rst_cout",  {{(N-1){1'b0}}, cout},  0);
        chk("mid_rst_ovf",   {{(N-1){1'b0}}, ovf},   0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_done", N'(n_done), N'(n_acc));

        run_op(64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0, 1'b0, 0);

        // Random back-to-back regression against an (N+1)-bit golden sum.
        for (int i = 0; i < 200; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom);
            rs = 1'($urandom);
            bb   = rs ? ~rb : rb;
            car  = rs ? 1'b1 : rc;
            full = {1'b0, ra} + {1'b0, bb} + {{N{1'b0}}, car};
            eov  = (ra[N-1] == bb[N-1]) && (full[N-1] != ra[N-1]);
            run_op(ra, rb, rc, rs, full[N-1:0], full[N], eov, 0);
        end

        repeat (4) @(negedge clk);
        chk("queue_empty", N'(q_exp.size()), 0);
        chk("done_count",  N'(n_done), N'(n_acc));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
